// File: rtl/core_pkg.sv
// core_pkg: shared pipeline-control types and constants for the RV32I core
package core_pkg;
  typedef enum logic [1:0] {HZ_RUN, HZ_MEM_WAIT, HZ_MULDIV} hz_state_e;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic stall_pc;
    logic stall_ifid;
    logic stall_idex;
    logic stall_exmem;
    logic flush_ifid;
    logic bubble_idex;
  } stage_ctrl_t;
endpackage

// File: rtl/hazard_perf_counter.sv
// hazard_perf_counter: wrapping event counter with enable
module hazard_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else count <= count + CNT_W'(en);
endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: pipeline stall/flush sequencer with stall and flush perf counters
// Optional mul/div occupancy stall is built only when MULDIV_STALL_EN is defined.
module hazard_stall_controller
  import core_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32,
  parameter int MULDIV_LAT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  muldiv_start,
  output logic                  stall_pc,
  output logic                  stall_ifid,
  output logic                  stall_idex,
  output logic                  stall_exmem,
  output logic                  flush_ifid,
  output logic                  bubble_idex,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);
  hz_state_e   state, state_nx, run_nx;
  stage_ctrl_t run_ctrl, ctrl;
  logic        load_use, mem_wait;
  assign load_use = ex_mem_read && ex_rd != REG_ZERO &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  assign mem_wait = mem_req && !mem_ready;
`ifdef MULDIV_STALL_EN
  localparam int CW = $clog2(MULDIV_LAT);
  logic [CW-1:0] cnt, cnt_nx;
`else
  localparam int unused_lat = MULDIV_LAT;
  logic unused_muldiv;
  assign unused_muldiv = muldiv_start;
`endif
  // decision taken when the pipeline is free to advance
  always_comb begin
    run_ctrl = '0;
    run_nx = HZ_RUN;
    if (mem_wait) begin
      run_ctrl.stall_pc = 1'b1;
      run_ctrl.stall_ifid = 1'b1;
      run_ctrl.stall_idex = 1'b1;
      run_ctrl.stall_exmem = 1'b1;
      run_nx = HZ_MEM_WAIT;
    end
`ifdef MULDIV_STALL_EN
    else if (muldiv_start) begin
      run_ctrl.stall_pc = 1'b1;
      run_ctrl.stall_ifid = 1'b1;
      run_ctrl.stall_idex = 1'b1;
      run_nx = HZ_MULDIV;
    end
`endif
    else if (ex_branch_taken) begin
      run_ctrl.flush_ifid = 1'b1;
      run_ctrl.bubble_idex = 1'b1;
    end else if (load_use) begin
      run_ctrl.stall_pc = 1'b1;
      run_ctrl.stall_ifid = 1'b1;
      run_ctrl.bubble_idex = 1'b1;
    end
  end
  always_comb begin
    ctrl = run_ctrl;
    state_nx = run_nx;
`ifdef MULDIV_STALL_EN
    cnt_nx = run_nx == HZ_MULDIV ? CW'(MULDIV_LAT - 1) : cnt;
`endif
    if (state == HZ_MEM_WAIT) begin
      ctrl = '0;
      ctrl.stall_pc = !mem_ready;
      ctrl.stall_ifid = !mem_ready;
      ctrl.stall_idex = !mem_ready;
      ctrl.stall_exmem = !mem_ready;
      state_nx = mem_ready ? HZ_RUN : HZ_MEM_WAIT;
    end
`ifdef MULDIV_STALL_EN
    // cnt==0 in MULDIV releases and decides like RUN in the same cycle
    else if (state == HZ_MULDIV && cnt != '0) begin
      ctrl = '0;
      ctrl.stall_pc = 1'b1;
      ctrl.stall_ifid = 1'b1;
      ctrl.stall_idex = 1'b1;
      ctrl.stall_exmem = mem_wait;
      state_nx = HZ_MULDIV;
      cnt_nx = cnt - 1'b1;
    end
`endif
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= HZ_RUN;
    else state <= state_nx;
`ifdef MULDIV_STALL_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= cnt_nx;
`endif
  assign {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, bubble_idex} =
    reset ? 6'b0 : ctrl;
  hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset(reset), .en(stall_pc), .count(stall_count)
  );
  hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .reset(reset), .en(flush_ifid), .count(flush_count)
  );
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed and random checks against a cycle-level behavioural model
module tb_hazard_stall_controller;
  localparam int LAT = 8;
`ifdef MULDIV_STALL_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready, muldiv_start;
  logic stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, bubble_idex;
  logic [31:0] stall_count, flush_count;
  int checks = 0, errors = 0;
  bit in_wait;
  int md_left;
  int unsigned n_stall, n_flush;
  wire [5:0] ctrl = {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, bubble_idex};

  hazard_stall_controller #(.MULDIV_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .muldiv_start(muldiv_start), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
    .stall_idex(stall_idex), .stall_exmem(stall_exmem), .flush_ifid(flush_ifid),
    .bubble_idex(bubble_idex), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic mr, input logic br, input logic mq,
                       input logic my, input logic md);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2; ex_rd = rd;
    ex_mem_read = mr; ex_branch_taken = br; mem_req = mq; mem_ready = my; muldiv_start = md;
  endtask

  // expected controls follow from the hazard rules; md_left = remaining mul/div stall cycles
  task automatic tick(input string tag);
    bit lu, mw, nw;
    int nmd;
    logic [5:0] e;
    lu = ex_mem_read && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    mw = mem_req && !mem_ready;
    nw = 1'b0;
    nmd = md_left > 0 ? md_left - 1 : 0;
    if (in_wait) begin
      e = mem_ready ? 6'b000000 : 6'b111100;
      nw = !mem_ready;
    end else if (md_left > 0) e = {3'b111, mw, 2'b00};
    else if (mw) begin
      e = 6'b111100;
      nw = 1'b1;
    end else if (MD_EN && muldiv_start) begin
      e = 6'b111000;
      nmd = LAT - 1;
    end else if (ex_branch_taken) e = 6'b000011;
    else if (lu) e = 6'b110001;
    else e = 6'b000000;
    @(negedge clk);
    check({tag, " ctrl"}, 32'(ctrl), 32'(e));
    check({tag, " stall_count"}, stall_count, n_stall);
    check({tag, " flush_count"}, flush_count, n_flush);
    @(posedge clk);
    n_stall += 32'(e[5]);
    n_flush += 32'(e[1]);
    in_wait = nw;
    md_left = nmd;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    in_wait = 0; md_left = 0; n_stall = 0; n_flush = 0;
    drive(5, 0, 1, 0, 5, 1, 1, 1, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    check("reset ctrl", 32'(ctrl), 0);
    check("reset stall_count", stall_count, 0);
    check("reset flush_count", flush_count, 0);
    reset = 1'b0;
    idle();
    tick("idle");
    drive(5, 0, 1, 0, 5, 1, 0, 0, 0, 0);
    tick("t1 load_use");
    idle();
    tick("t1 after");
    check("t1 stall_count", stall_count, 1);
    drive(5, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    tick("t2 x0");
    drive(0, 7, 0, 1, 7, 1, 0, 0, 0, 0);
    tick("rs2 load_use");
    drive(7, 0, 0, 1, 7, 1, 0, 0, 0, 0);
    tick("rs1 unused");
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (3) tick("t3 wait");
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tick("t3 ready");
    idle();
    tick("t3 after");
    check("t3 stall_count", stall_count, 5);
    drive(5, 0, 1, 0, 5, 1, 1, 0, 0, 0);
    tick("t4 branch");
    idle();
    tick("t4 after");
    check("t4 flush_count", flush_count, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick("t5 start");
    idle();
    repeat (LAT + 1) tick("t5 muldiv");
`ifdef MULDIV_STALL_EN
    check("t5 stall_count", stall_count, 5 + LAT);
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick("t6 wait1");
    reset = 1'b1;
    #1;
    check("t6 ctrl", 32'(ctrl), 0);
    check("t6 stall_count", stall_count, 0);
    check("t6 flush_count", flush_count, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_wait = 0; md_left = 0; n_stall = 0; n_flush = 0;
    drive(3, 0, 1, 0, 3, 1, 0, 0, 0, 0);
    tick("t6 run");
    for (int i = 0; i < 2000; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            5'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 19) == 0);
      tick("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
